reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 131 +++++++++++++
 tb/tb_reservation_station.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - eight-entry reservation station with dual-CDB wakeup and in-order-priority ALU issue
module reservation_station (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        Dispatch_S,
    input  logic [5:0]  Dispatch_Op,
    input  logic [31:0] Dispatch_A,
    input  logic [3:0]  Dispatch_Reorder,
    input  logic [31:0] Dispatch_pc,
    input  logic        Dispatch_Type_j,
    input  logic        Dispatch_Type_k,
    input  logic [31:0] Dispatch_Value_j,
    input  logic [31:0] Dispatch_Value_k,
    input  logic        ALU_CDB_S,
    input  logic [3:0]  ALU_CDB_Reorder,
    input  logic [31:0] ALU_CDB_Value,
    input  logic        LSB_CDB_S,
    input  logic [3:0]  LSB_CDB_Reorder,
    input  logic [31:0] LSB_CDB_Value,
    input  logic        ROB_clear,
    output logic        RS_full,
    output logic [2:0]  RS_free_pos,
    output logic        ALU_S,
    output logic [5:0]  ALU_Op,
    output logic [31:0] ALU_Vj,
    output logic [31:0] ALU_Vk,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_pc,
    output logic [3:0]  ALU_Reorder
);

    localparam int N = 8;

    logic [N-1:0] busy;
    logic [N-1:0] qj;
    logic [N-1:0] qk;
    logic [5:0]   op  [N];
    logic [31:0]  a   [N];
    logic [31:0]  pc  [N];
    logic [31:0]  vj  [N];
    logic [31:0]  vk  [N];
    logic [3:0]   rob [N];

    logic [N-1:0] ready;
    logic [2:0]   sel;
    logic         any_ready;

    // Replace a waiting tag with a CDB result; the ALU bus wins a tie.
    function automatic logic [32:0] resolve(input logic q, input logic [31:0] v);
        if (q && ALU_CDB_S && (ALU_CDB_Reorder == v[3:0]))
            return {1'b0, ALU_CDB_Value};
        if (q && LSB_CDB_S && (LSB_CDB_Reorder == v[3:0]))
            return {1'b0, LSB_CDB_Value};
        return {q, v};
    endfunction

    // Lowest free slot, full flag, and lowest ready slot from registered state.
    always_comb begin
        RS_free_pos = 3'd0;
        RS_full     = &busy;
        ready       = busy & ~qj & ~qk;
        sel         = 3'd0;
        any_ready   = |ready;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i])
                RS_free_pos = 3'(i);
            if (ready[i])
                sel = 3'(i);
        end
    end

    // Entry storage, wakeup, dispatch and issue register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            qj          <= '0;
            qk          <= '0;
            ALU_S       <= 1'b0;
            ALU_Op      <= '0;
            ALU_Vj      <= '0;
            ALU_Vk      <= '0;
            ALU_A       <= '0;
            ALU_pc      <= '0;
            ALU_Reorder <= '0;
            for (int i = 0; i < N; i++) begin
                op[i]  <= '0;
                a[i]   <= '0;
                pc[i]  <= '0;
                vj[i]  <= '0;
                vk[i]  <= '0;
                rob[i] <= '0;
            end
        end else if (rdy) begin
            if (ROB_clear) begin
                busy  <= '0;
                ALU_S <= 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (busy[i]) begin
                        {qj[i], vj[i]} <= resolve(qj[i], vj[i]);
                        {qk[i], vk[i]} <= resolve(qk[i], vk[i]);
                    end
                end
                if (any_ready) begin
                    ALU_S       <= 1'b1;
                    ALU_Op      <= op[sel];
                    ALU_Vj      <= vj[sel];
                    ALU_Vk      <= vk[sel];
                    ALU_A       <= a[sel];
                    ALU_pc      <= pc[sel];
                    ALU_Reorder <= rob[sel];
                    busy[sel]   <= 1'b0;
                end else begin
                    ALU_S <= 1'b0;
                end
                // The free slot is never the issuing slot, so both writes coexist.
                if (Dispatch_S && !RS_full) begin
                    busy[RS_free_pos] <= 1'b1;
                    op[RS_free_pos]   <= Dispatch_Op;
                    a[RS_free_pos]    <= Dispatch_A;
                    pc[RS_free_pos]   <= Dispatch_pc;
                    rob[RS_free_pos]  <= Dispatch_Reorder;
                    {qj[RS_free_pos], vj[RS_free_pos]} <= resolve(Dispatch_Type_j, Dispatch_Value_j);
                    {qk[RS_free_pos], vk[RS_free_pos]} <= resolve(Dispatch_Type_k, Dispatch_Value_k);
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - randomized scoreboard bench for reservation_station
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        Dispatch_S, Dispatch_Type_j, Dispatch_Type_k;
    logic [5:0]  Dispatch_Op;
    logic [31:0] Dispatch_A, Dispatch_pc, Dispatch_Value_j, Dispatch_Value_k;
    logic [3:0]  Dispatch_Reorder;
    logic        ALU_CDB_S, LSB_CDB_S;
    logic [3:0]  ALU_CDB_Reorder, LSB_CDB_Reorder;
    logic [31:0] ALU_CDB_Value, LSB_CDB_Value;
    logic        ROB_clear;
    logic        RS_full;
    logic [2:0]  RS_free_pos;
    logic        ALU_S;
    logic [5:0]  ALU_Op;
    logic [31:0] ALU_Vj, ALU_Vk, ALU_A, ALU_pc;
    logic [3:0]  ALU_Reorder;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .Dispatch_S(Dispatch_S), .Dispatch_Op(Dispatch_Op), .Dispatch_A(Dispatch_A),
        .Dispatch_Reorder(Dispatch_Reorder), .Dispatch_pc(Dispatch_pc),
        .Dispatch_Type_j(Dispatch_Type_j), .Dispatch_Type_k(Dispatch_Type_k),
        .Dispatch_Value_j(Dispatch_Value_j), .Dispatch_Value_k(Dispatch_Value_k),
        .ALU_CDB_S(ALU_CDB_S), .ALU_CDB_Reorder(ALU_CDB_Reorder), .ALU_CDB_Value(ALU_CDB_Value),
        .LSB_CDB_S(LSB_CDB_S), .LSB_CDB_Reorder(LSB_CDB_Reorder), .LSB_CDB_Value(LSB_CDB_Value),
        .ROB_clear(ROB_clear), .RS_full(RS_full), .RS_free_pos(RS_free_pos),
        .ALU_S(ALU_S), .ALU_Op(ALU_Op), .ALU_Vj(ALU_Vj), .ALU_Vk(ALU_Vk),
        .ALU_A(ALU_A), .ALU_pc(ALU_pc), .ALU_Reorder(ALU_Reorder)
    );

    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit [31:0] a, pc, vj, vk;
        bit [3:0]  rob;
        bit        wj, wk;
    } ent_t;

    typedef struct {
        bit [5:0]  op;
        bit [31:0] vj, vk, a, pc;
        bit [3:0]  rob;
    } iss_t;

    ent_t m [8];
    iss_t exp_q [$];
    bit   m_alu_s;
    bit   edge_act, edge_rst, started;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        foreach (m[i]) if (m[i].busy) c++;
        return c;
    endfunction

    function automatic int m_free();
        foreach (m[i]) if (!m[i].busy) return i;
        return 0;
    endfunction

    // Resolve one operand against the buses as they stand this cycle; ALU bus first.
    task automatic wake(inout bit w, inout bit [31:0] v);
        if (w && ALU_CDB_S && ALU_CDB_Reorder == v[3:0]) begin
            w = 0; v = ALU_CDB_Value;
        end else if (w && LSB_CDB_S && LSB_CDB_Reorder == v[3:0]) begin
            w = 0; v = LSB_CDB_Value;
        end
    endtask

    // Reference: effect of the coming clock edge on the abstract station.
    task automatic model_step();
        int pick, slot;
        bit was_full;
        ent_t e;
        edge_act = !rst && rdy;
        edge_rst = rst;
        if (rst) begin
            foreach (m[i]) m[i] = '{default: 0};
            m_alu_s = 0;
        end else if (rdy && ROB_clear) begin
            foreach (m[i]) m[i].busy = 0;
            m_alu_s = 0;
        end else if (rdy) begin
            was_full = (m_count() == 8);
            slot = m_free();
            pick = -1;
            foreach (m[i]) if (pick < 0 && m[i].busy && !m[i].wj && !m[i].wk) pick = i;
            foreach (m[i]) if (m[i].busy) begin
                wake(m[i].wj, m[i].vj);
                wake(m[i].wk, m[i].vk);
            end
            if (pick >= 0) begin
                exp_q.push_back('{m[pick].op, m[pick].vj, m[pick].vk, m[pick].a, m[pick].pc, m[pick].rob});
                m[pick].busy = 0;
            end
            m_alu_s = (pick >= 0);
            if (Dispatch_S && !was_full) begin
                e.busy = 1; e.op = Dispatch_Op; e.a = Dispatch_A; e.pc = Dispatch_pc;
                e.rob = Dispatch_Reorder;
                e.wj = Dispatch_Type_j; e.vj = Dispatch_Value_j;
                e.wk = Dispatch_Type_k; e.vk = Dispatch_Value_k;
                wake(e.wj, e.vj);
                wake(e.wk, e.vk);
                m[slot] = e;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        started = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        Dispatch_S = 0; Dispatch_Op = 0; Dispatch_A = 0; Dispatch_pc = 0; Dispatch_Reorder = 0;
        Dispatch_Type_j = 0; Dispatch_Type_k = 0; Dispatch_Value_j = 0; Dispatch_Value_k = 0;
        ALU_CDB_S = 0; ALU_CDB_Reorder = 0; ALU_CDB_Value = 0;
        LSB_CDB_S = 0; LSB_CDB_Reorder = 0; LSB_CDB_Value = 0;
        ROB_clear = 0; rst = 0; rdy = 1;
    endtask

    task automatic disp(input bit [5:0] o, input bit [3:0] r, input bit tj, input bit [31:0] vj_in,
                        input bit tk, input bit [31:0] vk_in);
        Dispatch_S = 1; Dispatch_Op = o; Dispatch_Reorder = r;
        Dispatch_A = $urandom; Dispatch_pc = $urandom;
        Dispatch_Type_j = tj; Dispatch_Value_j = vj_in;
        Dispatch_Type_k = tk; Dispatch_Value_k = vk_in;
    endtask

    // Monitor: compare status every cycle and pop an expected issue per ALU_S pulse.
    always @(posedge clk) begin
        iss_t x;
        #1;
        if (started) begin
            check("alu_s", {31'b0, ALU_S}, {31'b0, m_alu_s});
            check("rs_full", {31'b0, RS_full}, {31'b0, (m_count() == 8)});
            check("rs_free_pos", {29'b0, RS_free_pos}, m_free());
            if (edge_rst) begin
                check("reset_alu_data", {26'b0, ALU_Op} | ALU_Vj | ALU_Vk | ALU_A | ALU_pc | {28'b0, ALU_Reorder}, 0);
            end
            if (ALU_S && edge_act) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    check("alu_op", {26'b0, ALU_Op}, {26'b0, x.op});
                    check("alu_vj", ALU_Vj, x.vj);
                    check("alu_vk", ALU_Vk, x.vk);
                    check("alu_a", ALU_A, x.a);
                    check("alu_pc", ALU_pc, x.pc);
                    check("alu_reorder", {28'b0, ALU_Reorder}, {28'b0, x.rob});
                end
            end
            if (exp_q.size() != 0) begin
                check("missing_issue", exp_q.size(), 0);
                exp_q.delete();
            end
        end
    end

    initial begin
        int p_cdb;
        bit [3:0] t;
        started = 0;
        idle();
        rst = 1;
        cycle(); cycle();
        idle();
        cycle();

        // Ready dispatch.
        disp(6'd1, 4'd3, 0, 32'd5, 0, 32'd7); cycle();
        idle(); cycle(); cycle();

        // Wakeup through ALU CDB.
        disp(6'd2, 4'd4, 1, 32'd2, 0, 32'd1); cycle();
        idle(); cycle();
        ALU_CDB_S = 1; ALU_CDB_Reorder = 2; ALU_CDB_Value = 32'h1234; cycle();
        idle(); cycle(); cycle();

        // Same-cycle bypass from LSB CDB, plus an ALU/LSB tie.
        disp(6'd3, 4'd5, 0, 32'd8, 1, 32'd6);
        LSB_CDB_S = 1; LSB_CDB_Reorder = 6; LSB_CDB_Value = 32'd9; cycle();
        idle(); cycle(); cycle();
        disp(6'd4, 4'd6, 1, 32'd7, 0, 32'd0);
        ALU_CDB_S = 1; ALU_CDB_Reorder = 7; ALU_CDB_Value = 32'hA;
        LSB_CDB_S = 1; LSB_CDB_Reorder = 7; LSB_CDB_Value = 32'hB; cycle();
        idle(); cycle(); cycle();

        // Fill with waiting entries, overflow, out-of-order wake, then flush.
        for (int i = 0; i < 9; i++) begin
            disp(6'(i), 4'(i), 1, 32'(8 + (i % 8)), 0, 32'(i)); cycle();
        end
        idle(); cycle();
        ALU_CDB_S = 1; ALU_CDB_Reorder = 13; ALU_CDB_Value = 32'h55;
        LSB_CDB_S = 1; LSB_CDB_Reorder = 10; LSB_CDB_Value = 32'h22; cycle();
        idle(); cycle(); cycle(); cycle();
        ROB_clear = 1; cycle();
        idle(); cycle(); cycle();

        // Freeze with a ready entry present.
        disp(6'd9, 4'd9, 0, 32'd1, 0, 32'd2); cycle();
        idle(); rdy = 0; cycle(); cycle(); cycle();
        idle(); cycle(); cycle();

        // Randomized traffic with varying CDB pressure.
        for (int n = 0; n < 4000; n++) begin
            if (n % 400 == 0) p_cdb = $urandom_range(5, 70);
            idle();
            if ($urandom_range(0, 99) < 55) begin
                t = 4'($urandom_range(0, 7));
                disp(6'($urandom), 4'($urandom),
                     1'($urandom), {$urandom} & 32'hFFFF_FFF0 | 32'(t),
                     1'($urandom), {$urandom} & 32'hFFFF_FFF0 | 32'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 99) < p_cdb) begin
                ALU_CDB_S = 1; ALU_CDB_Reorder = 4'($urandom_range(0, 7)); ALU_CDB_Value = $urandom;
            end
            if ($urandom_range(0, 99) < p_cdb) begin
                LSB_CDB_S = 1; LSB_CDB_Reorder = 4'($urandom_range(0, 7)); LSB_CDB_Value = $urandom;
            end
            rdy = ($urandom_range(0, 9) != 0);
            ROB_clear = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end

        idle(); cycle(); cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
